// File: rtl/mem_dot_product_reader.sv
// Weight-memory reader that accumulates a signed dot product of streamed samples
// against stored weights. Define MEM_DOT_RELU_EN to clamp negative results to zero.
module mem_dot_product_reader #(
  parameter int wordsize = 8,
  parameter int addrsize = 4,
  parameter int accsize  = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [addrsize:0]          length,
  input  logic signed [wordsize-1:0] x_data,
  input  logic                       x_valid,
  output logic                       x_ready,
  output logic [addrsize-1:0]        mem_addr,
  input  logic signed [wordsize-1:0] mem_readdata,
  output logic signed [accsize-1:0]  result,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [addrsize:0] idx_one = 1;

  state_t                       state;
  logic [addrsize:0]            idx;
  logic [addrsize:0]            len;
  logic [addrsize:0]            next_idx;
  logic signed [accsize-1:0]    acc;
  logic signed [2*wordsize-1:0] prod;
  logic                         beat;

  function automatic logic signed [accsize-1:0] widen(input logic signed [2*wordsize-1:0] p);
    widen = accsize'(p);
  endfunction

  function automatic logic signed [accsize-1:0] relu(input logic signed [accsize-1:0] a);
    relu = (a < 0) ? '0 : a;
  endfunction

  assign beat     = x_valid & x_ready;
  assign prod     = (2*wordsize)'(x_data) * (2*wordsize)'(mem_readdata);
  assign next_idx = idx + idx_one;

  // Control and accumulator: the count uses addrsize+1 bits so a full-length
  // vector ends on idx == 2**addrsize-1 without wrapping first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      idx          <= '0;
      len          <= '0;
      x_ready      <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      mem_addr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            idx      <= '0;
            len      <= length;
            mem_addr <= '0;
            busy     <= 1'b1;
            if (length != '0) begin
              state   <= RUN;
              x_ready <= 1'b1;
            end else begin
              state        <= DONE;
              result_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (beat) begin
            acc <= acc + widen(prod);
            idx <= next_idx;
            if (idx == len - idx_one) begin
              state        <= DONE;
              x_ready      <= 1'b0;
              result_valid <= 1'b1;
            end else begin
              mem_addr <= next_idx[addrsize-1:0];
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            mem_addr     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result is a direct view of the final sum while DONE.
  always_comb begin
    result = '0;
    if (state == DONE) begin
`ifdef MEM_DOT_RELU_EN
      result = relu(acc);
`else
      result = acc;
`endif
    end
  end

endmodule
